// File: rtl/fmint_dw_fetch.sv
// Window fetcher for the depthwise stage: sweeps the FMINT tile channel-major and
// assembles one zero-padded 3x3 window per output pixel from a 1-cycle-latency RAM.
module fmint_dw_fetch #(
   parameter  int PX_W   = 8,
   parameter  int TILE_H = 8,
   parameter  int TILE_W = 8,
   parameter  int N_CH   = 4,
   localparam int ADDR_W = $clog2(N_CH * TILE_H * TILE_W)
) (
   input  logic                clk,
   input  logic                rst,
   input  logic                start,
   output logic                busy,
   output logic                done,
   output logic [ADDR_W-1:0]   ram_addr,
   input  logic [PX_W-1:0]     ram_rd_data,
   output logic [9*PX_W-1:0]   win_data,
   output logic                win_valid,
   input  logic                win_ready
);

   localparam int CH_W  = (N_CH   > 1) ? $clog2(N_CH)   : 1;
   localparam int ROW_W = (TILE_H > 1) ? $clog2(TILE_H) : 1;
   localparam int COL_W = (TILE_W > 1) ? $clog2(TILE_W) : 1;

   typedef enum logic [1:0] {IDLE, FETCH, HOLD, DONE} state_t;

   state_t              state_q, state_d;
   logic [3:0]          cyc_q, cyc_d;
   logic [CH_W-1:0]     ch_q, ch_d, ch_n;
   logic [ROW_W-1:0]    row_q, row_d, row_n;
   logic [COL_W-1:0]    col_q, col_d, col_n;
   logic [ADDR_W-1:0]   addr_q, addr_d;
   logic [9*PX_W-1:0]   lanes_q, lanes_d;
   logic                last_pos;
   logic [3:0]          cap_idx;

   // Out-of-bounds taps point at the centre pixel so the address stays in range.
   function automatic logic tap_oob(input int row, input int col, input int k);
      int r;
      int c;
      r = row + k / 3 - 1;
      c = col + k % 3 - 1;
      return (r < 0) || (r >= TILE_H) || (c < 0) || (c >= TILE_W);
   endfunction

   function automatic logic [ADDR_W-1:0] tap_addr(input int ch, input int row, input int col,
                                                   input int k);
      int a;
      if (tap_oob(row, col, k))
         a = (ch * TILE_H + row) * TILE_W + col;
      else
         a = (ch * TILE_H + row + k / 3 - 1) * TILE_W + col + k % 3 - 1;
      return ADDR_W'(a);
   endfunction

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         cyc_q   <= '0;
         ch_q    <= '0;
         row_q   <= '0;
         col_q   <= '0;
         addr_q  <= '0;
         lanes_q <= '0;
      end else begin
         state_q <= state_d;
         cyc_q   <= cyc_d;
         ch_q    <= ch_d;
         row_q   <= row_d;
         col_q   <= col_d;
         addr_q  <= addr_d;
         lanes_q <= lanes_d;
      end
   end

   assign last_pos = (ch_q == CH_W'(N_CH - 1)) && (row_q == ROW_W'(TILE_H - 1)) &&
                     (col_q == COL_W'(TILE_W - 1));

   always_comb begin
      ch_n  = ch_q;
      row_n = row_q;
      col_n = col_q;
      if (col_q == COL_W'(TILE_W - 1)) begin
         col_n = '0;
         if (row_q == ROW_W'(TILE_H - 1)) begin
            row_n = '0;
            ch_n  = ch_q + 1'b1;
         end else begin
            row_n = row_q + 1'b1;
         end
      end else begin
         col_n = col_q + 1'b1;
      end
   end

   always_comb begin
      state_d = state_q;
      case (state_q)
         IDLE:    if (start) state_d = FETCH;
         FETCH:   if (cyc_q == 4'd9) state_d = HOLD;
         HOLD:    if (win_ready) state_d = last_pos ? DONE : FETCH;
         DONE:    state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   // After edge E(j) cyc_q holds j: the next edge issues tap j+1 and captures lane j-1.
   always_comb begin
      cyc_d   = cyc_q;
      ch_d    = ch_q;
      row_d   = row_q;
      col_d   = col_q;
      addr_d  = addr_q;
      lanes_d = lanes_q;
      cap_idx = cyc_q - 4'd1;
      case (state_q)
         IDLE: begin
            if (start) begin
               cyc_d  = '0;
               ch_d   = '0;
               row_d  = '0;
               col_d  = '0;
               addr_d = tap_addr(0, 0, 0, 0);
            end
         end
         FETCH: begin
            cyc_d = cyc_q + 4'd1;
            if (cyc_q <= 4'd7)
               addr_d = tap_addr(int'(ch_q), int'(row_q), int'(col_q), int'(cyc_q) + 1);
            if (cyc_q >= 4'd1) begin
               if (tap_oob(int'(row_q), int'(col_q), int'(cap_idx)))
                  lanes_d[cap_idx*PX_W +: PX_W] = '0;
               else
                  lanes_d[cap_idx*PX_W +: PX_W] = ram_rd_data;
            end
         end
         HOLD: begin
            if (win_ready) begin
               cyc_d = '0;
               if (last_pos) begin
                  ch_d  = '0;
                  row_d = '0;
                  col_d = '0;
               end else begin
                  ch_d   = ch_n;
                  row_d  = row_n;
                  col_d  = col_n;
                  addr_d = tap_addr(int'(ch_n), int'(row_n), int'(col_n), 0);
               end
            end
         end
         default: ;
      endcase
   end

   always_comb begin
      busy      = (state_q != IDLE);
      done      = (state_q == DONE);
      win_valid = (state_q == HOLD);
      ram_addr  = addr_q;
      win_data  = lanes_q;
   end

endmodule

// File: tb/tb_fmint_dw_fetch.sv
// Directed bench for fmint_dw_fetch on an 8x8x4 tile with mem[a]=a preloaded.
module tb_fmint_dw_fetch;
   localparam int PX_W = 8;
   localparam int ADDR_W = 8;

   logic              clk = 1'b0;
   logic              rst, start, win_ready;
   logic              busy, done, win_valid;
   logic [ADDR_W-1:0] ram_addr;
   logic [PX_W-1:0]   ram_rd_data;
   logic [71:0]       win_data;

   logic [7:0]  mem [256];
   logic [71:0] win_log [256];
   int checks = 0;
   int fails = 0;
   int hs_count = 0;
   int done_count = 0;

   // Lane 8 is the most significant byte.
   localparam logic [71:0] EXP_FIRST = {8'd9, 8'd8, 8'd0, 8'd1, 8'd0, 8'd0, 8'd0, 8'd0, 8'd0};
   localparam logic [71:0] EXP_W92   = {8'd101, 8'd100, 8'd99, 8'd93, 8'd92, 8'd91,
                                        8'd85, 8'd84, 8'd83};
   localparam logic [71:0] EXP_LAST  = {8'd0, 8'd0, 8'd0, 8'd0, 8'd255, 8'd254,
                                        8'd0, 8'd247, 8'd246};

   fmint_dw_fetch #(.PX_W(8), .TILE_H(8), .TILE_W(8), .N_CH(4)) dut (
      .clk(clk), .rst(rst), .start(start), .busy(busy), .done(done),
      .ram_addr(ram_addr), .ram_rd_data(ram_rd_data), .win_data(win_data),
      .win_valid(win_valid), .win_ready(win_ready)
   );

   always #5 clk = ~clk;

   initial for (int a = 0; a < 256; a++) mem[a] = 8'(a);

   always @(posedge clk) ram_rd_data <= mem[ram_addr];

   always @(negedge clk) begin
      if (!rst) begin
         if (win_valid && win_ready) begin
            if (hs_count < 256) win_log[hs_count] = win_data;
            hs_count = hs_count + 1;
         end
         if (done) done_count = done_count + 1;
      end
   end

   task automatic chk(input string tag, input logic [71:0] obs, input logic [71:0] exp);
      checks++;
      assert (obs === exp) else begin
         fails++;
         $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   initial begin
      rst = 1'b1; start = 1'b0; win_ready = 1'b0;
      repeat (3) step();
      chk("rst_busy", 72'(busy), 72'd0);
      chk("rst_done", 72'(done), 72'd0);
      chk("rst_valid", 72'(win_valid), 72'd0);
      chk("rst_data", win_data, 72'd0);
      chk("rst_addr", 72'(ram_addr), 72'd0);
      rst = 1'b0;
      step();

      // First window: launch at E0, valid after E10; hold ready low.
      start = 1'b1;
      step();
      start = 1'b0;
      chk("busy_after_start", 72'(busy), 72'd1);
      for (int i = 1; i <= 9; i++) begin
         step();
         if (i == 7) chk("addr_tap7", 72'(ram_addr), 72'd8);
         if (i == 9) chk("valid_before_e10", 72'(win_valid), 72'd0);
      end
      step();
      chk("valid_at_e10", 72'(win_valid), 72'd1);
      chk("first_window", win_data, EXP_FIRST);
      for (int i = 0; i < 5; i++) begin
         step();
         chk("hold_valid", 72'(win_valid), 72'd1);
         chk("hold_data", win_data, EXP_FIRST);
         chk("hold_addr", 72'(ram_addr), 72'd9);
      end
      win_ready = 1'b1;
      step();
      chk("valid_drop_on_hs", 72'(win_valid), 72'd0);
      chk("hs_count_first", 72'(hs_count), 72'd1);
      chk("logged_first", win_log[0], EXP_FIRST);

      // Start while busy must be ignored.
      repeat (4) step();
      start = 1'b1;
      step();
      start = 1'b0;

      for (int i = 0; i < 5000 && done_count == 0; i++) step();
      chk("done_seen", 72'(done_count), 72'd1);
      chk("busy_after_done", 72'(busy), 72'd0);
      chk("done_one_cycle", 72'(done), 72'd0);
      repeat (3) step();
      chk("done_pulses", 72'(done_count), 72'd1);
      chk("hs_total", 72'(hs_count), 72'd256);
      chk("window_92", win_log[92], EXP_W92);
      chk("window_last", win_log[255], EXP_LAST);

      // Abort mid-sweep after 37 handshakes.
      hs_count = 0;
      start = 1'b1;
      step();
      start = 1'b0;
      for (int i = 0; i < 2000 && hs_count < 37; i++) step();
      chk("reached_37", 72'(hs_count), 72'd37);
      rst = 1'b1;
      step();
      rst = 1'b0;
      chk("abort_busy", 72'(busy), 72'd0);
      chk("abort_valid", 72'(win_valid), 72'd0);
      chk("abort_done", 72'(done), 72'd0);
      chk("abort_data", win_data, 72'd0);
      chk("abort_addr", 72'(ram_addr), 72'd0);
      repeat (30) step();
      chk("abort_no_done", 72'(done_count), 72'd1);
      chk("abort_idle", 72'(busy), 72'd0);

      win_ready = 1'b0;
      start = 1'b1;
      step();
      start = 1'b0;
      repeat (9) step();
      chk("restart_valid_e9", 72'(win_valid), 72'd0);
      step();
      chk("restart_valid_e10", 72'(win_valid), 72'd1);
      chk("restart_window", win_data, EXP_FIRST);

      $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
      $finish;
   end
endmodule
